// File: rtl/eddy_acq_pkg.sv
// Shared types and default parameters for the eddy-current ADC acquisition block.
package eddy_acq_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StConvert = 2'd1,
        StShift   = 2'd2
    } acq_state_e;

    localparam int unsigned DefDataWidth  = 18;
    localparam int unsigned DefConvCycles = 100;
    localparam int unsigned DefSclkDiv    = 4;

    // Counter width for a terminal count, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sclk_gen.sv
// Enable-gated serial clock divider: sclk toggles every SCLK_DIV cycles while
// enabled and is held low with the divider cleared when disabled.
module sclk_gen #(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    import eddy_acq_pkg::*;

    localparam int unsigned DivW = cnt_width(SCLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(SCLK_DIV - 1);

    logic [DivW-1:0] cnt_q, cnt_d;
    logic            sclk_q, sclk_d;
    logic            tick;

    // Half-period counter and toggle; rise/fall flag the edge on which sclk flips.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        tick   = en && (cnt_q == DivLast);
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (cnt_q == DivLast) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise = tick && !sclk_q;
        fall = tick && sclk_q;
    end

    // Divider state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/eddy_current_sensor_acq.sv
// Trigger/enable/done responder that runs one conversion-and-serial-read of an
// eddy-current ADC per accepted trigger and holds the sample with a level done.
module eddy_current_sensor_acq
    import eddy_acq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned CONV_CYCLES = DefConvCycles,
    parameter int unsigned SCLK_DIV    = DefSclkDiv
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic                  en,
    input  logic                  miso,
    output logic                  cnv,
    output logic                  sclk,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  done,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned ConvW = $clog2(CONV_CYCLES + 1);
    localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);
    localparam logic [ConvW-1:0] ConvLast = ConvW'(CONV_CYCLES - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH);

    acq_state_e            state_q, state_d;
    logic [ConvW-1:0]      conv_cnt_q, conv_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  cnv_q, cnv_d;
    logic                  overrun_q, overrun_d;

    logic sclk_en, sclk_rise, sclk_fall;

    // Gating with en makes an abort pull sclk low on the same edge the FSM leaves SHIFT.
    assign sclk_en = (state_q == StShift) && en;

    sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (sclk_en),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Next-state logic for the acquisition FSM and its registered outputs.
    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        done_d     = done_q;
        busy_d     = busy_q;
        cnv_d      = cnv_q;
        overrun_d  = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (trigger && en) begin
                    state_d    = StConvert;
                    conv_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shreg_d    = '0;
                    done_d     = 1'b0;
                    overrun_d  = 1'b0;
                    busy_d     = 1'b1;
                    cnv_d      = 1'b1;
                end
            end
            StConvert: begin
                if (!en) begin
                    state_d    = StIdle;
                    conv_cnt_d = '0;
                    busy_d     = 1'b0;
                    cnv_d      = 1'b0;
                end else begin
                    if (trigger) begin
                        overrun_d = 1'b1;
                    end
                    if (conv_cnt_q == ConvLast) begin
                        state_d    = StShift;
                        conv_cnt_d = '0;
                        cnv_d      = 1'b0;
                    end else begin
                        conv_cnt_d = conv_cnt_q + 1'b1;
                    end
                end
            end
            StShift: begin
                if (!en) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    // A trigger on the completion edge still counts as an overrun.
                    if (trigger) begin
                        overrun_d = 1'b1;
                    end
                    if (sclk_rise) begin
                        shreg_d   = {shreg_q[DATA_WIDTH-2:0], miso};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    // Completion on the falling edge after the last bit's high half.
                    if (sclk_fall && (bit_cnt_q == BitLast)) begin
                        state_d   = StIdle;
                        bit_cnt_d = '0;
                        data_d    = shreg_q;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            conv_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            cnv_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            cnv_q      <= cnv_d;
            overrun_q  <= overrun_d;
        end
    end

    assign cnv     = cnv_q;
    assign data    = data_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_eddy_current_sensor_acq.sv
// Bench for eddy_current_sensor_acq: default instance driven from a vector table
// and random runs, plus a small-parameter instance for the fast corner.
module tb_eddy_current_sensor_acq;

    localparam int DW   = 18;
    localparam int CONV = 100;
    localparam int DIV  = 4;
    localparam int LAT  = 1 + CONV + 2 * DIV * DW;
    localparam int S_DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic trigger, en, miso;
    logic cnv, sclk, done, busy, overrun;
    logic [DW-1:0] data;

    logic s_trigger, s_en, s_miso;
    logic s_cnv, s_sclk, s_done, s_busy, s_overrun;
    logic [S_DW-1:0] s_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    eddy_current_sensor_acq dut (
        .clk     (clk),
        .rst     (rst),
        .trigger (trigger),
        .en      (en),
        .miso    (miso),
        .cnv     (cnv),
        .sclk    (sclk),
        .data    (data),
        .done    (done),
        .busy    (busy),
        .overrun (overrun)
    );

    eddy_current_sensor_acq #(
        .DATA_WIDTH  (S_DW),
        .CONV_CYCLES (1),
        .SCLK_DIV    (1)
    ) dut_s (
        .clk     (clk),
        .rst     (rst),
        .trigger (s_trigger),
        .en      (s_en),
        .miso    (s_miso),
        .cnv     (s_cnv),
        .sclk    (s_sclk),
        .data    (s_data),
        .done    (s_done),
        .busy    (s_busy),
        .overrun (s_overrun)
    );

    // ADC model: MSB presented at conversion start, next bit after each sclk fall.
    logic [31:0] adc_pat = '0;
    logic [4:0]  adc_idx = '0;
    int          rise_cnt = 0;
    always @(posedge cnv or negedge sclk) begin
        if (cnv) adc_idx = 5'(DW - 1);
        else if (adc_idx != 0) adc_idx = adc_idx - 1'b1;
    end
    assign miso = adc_pat[adc_idx];
    always @(posedge sclk) rise_cnt = rise_cnt + 1;

    logic [31:0] s_adc_pat = '0;
    logic [4:0]  s_adc_idx = '0;
    int          s_rise_cnt = 0;
    always @(posedge s_cnv or negedge s_sclk) begin
        if (s_cnv) s_adc_idx = 5'(S_DW - 1);
        else if (s_adc_idx != 0) s_adc_idx = s_adc_idx - 1'b1;
    end
    assign s_miso = s_adc_pat[s_adc_idx];
    always @(posedge s_sclk) s_rise_cnt = s_rise_cnt + 1;

    logic [31:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One acquisition on the default instance; trigger is sampled at edge 1.
    // abort_at/trig2_at: cycle in which en drops / a second trigger is driven (0 = none).
    task automatic acquire(input string tag, input logic [31:0] pat, input int abort_at,
                           input int trig2_at);
        int   k, done_at, cnv_cnt, first_sclk, exp_cnv;
        logic clr_done, clr_ovr, ab_sclk, ab_busy, ab_cnv, busy_ok, busy_at_done, exp_ovr;
        bit   aborted;
        aborted = (abort_at > 0);
        adc_pat = pat;
        rise_cnt = 0;
        k = 0; done_at = 0; cnv_cnt = 0; first_sclk = 0;
        clr_done = 1'b1; clr_ovr = 1'b1; ab_sclk = 1'b1; ab_busy = 1'b1; ab_cnv = 1'b1;
        busy_ok = 1'b1; busy_at_done = 1'b1;
        trigger = 1'b1;
        while (k < LAT + 20) begin
            @(posedge clk);
            #1;
            k++;
            trigger = (trig2_at > 0) && (k == trig2_at);
            if (k == 1) begin
                clr_done = done;
                clr_ovr  = overrun;
            end
            if (cnv) cnv_cnt++;
            if (sclk && first_sclk == 0) first_sclk = k;
            if (!aborted && k < LAT && !busy) busy_ok = 1'b0;
            if (done && done_at == 0) begin
                done_at = k;
                busy_at_done = busy;
            end
            if (aborted && k == abort_at + 1) begin
                ab_sclk = sclk;
                ab_busy = busy;
                ab_cnv  = cnv;
            end
            if (aborted && k == abort_at) en = 1'b0;
            if (!aborted && done_at != 0) break;
            if (aborted && k == abort_at + 8) break;
        end
        trigger = 1'b0;

        exp_cnv = (aborted && abort_at < CONV) ? abort_at : CONV;
        exp_ovr = (trig2_at > 0) && (trig2_at < LAT) && (!aborted || trig2_at < abort_at);
        check({tag, " done_cleared"}, 32'(clr_done), 0);
        check({tag, " overrun_cleared"}, 32'(clr_ovr), 0);
        check({tag, " cnv_cycles"}, cnv_cnt, exp_cnv);
        check({tag, " overrun"}, 32'(overrun), 32'(exp_ovr));
        if (!aborted) begin
            check({tag, " done_latency"}, done_at, LAT);
            check({tag, " data"}, 32'(data), pat & 32'h3FFFF);
            check({tag, " sclk_rises"}, rise_cnt, DW);
            check({tag, " first_sclk"}, first_sclk, 1 + CONV + DIV);
            check({tag, " busy_during"}, 32'(busy_ok), 1);
            check({tag, " busy_at_done"}, 32'(busy_at_done), 0);
            last_data = pat & 32'h3FFFF;
        end else begin
            check({tag, " abort_done"}, done_at, 0);
            check({tag, " abort_data"}, 32'(data), last_data);
            check({tag, " abort_sclk"}, 32'(ab_sclk), 0);
            check({tag, " abort_busy"}, 32'(ab_busy), 0);
            check({tag, " abort_cnv"}, 32'(ab_cnv), 0);
            en = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] pat;
        int          abort_at;
        int          trig2_at;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   k, done_at;
        logic any_out;

        vecs[0] = '{"basic",        32'h2A5C3, 0,   0};
        vecs[1] = '{"overrun100",   32'h15A3C, 0,   100};
        vecs[2] = '{"overrun_last", 32'h3FFFF, 0,   244};
        vecs[3] = '{"abort_shift",  32'h00001, 150, 0};
        vecs[4] = '{"abort_sclkhi", 32'h2AAAA, 146, 0};
        vecs[5] = '{"abort_conv",   32'h20000, 50,  50};
        vecs[6] = '{"after_abort",  32'h0F0F0, 0,   0};

        rst = 1'b1; trigger = 1'b0; en = 1'b0;
        s_trigger = 1'b0; s_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle with enable high and no trigger: nothing may move.
        en = 1'b1;
        rise_cnt = 0;
        any_out = 1'b0;
        check("reset data", 32'(data), 0);
        check("reset done", 32'(done), 0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            any_out = any_out | cnv | sclk | done | busy | overrun | (|data);
        end
        check("idle outputs", 32'(any_out), 0);
        check("idle sclk_rises", rise_cnt, 0);

        // Small-parameter instance: 8 bits, 1-cycle convert, 1-cycle half-period.
        check("s reset data", 32'(s_data), 0);
        s_en = 1'b1;
        s_adc_pat = 32'hA5;
        s_rise_cnt = 0;
        s_trigger = 1'b1;
        done_at = 0;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            s_trigger = 1'b0;
            if (s_done && done_at == 0) done_at = k;
            if (done_at != 0) break;
        end
        check("s done_latency", done_at, 18);
        check("s data", 32'(s_data), 32'hA5);
        check("s sclk_rises", s_rise_cnt, S_DW);
        check("s busy_at_done", 32'(s_busy), 0);

        for (int i = 0; i < 7; i++) begin
            acquire(vecs[i].tag, vecs[i].pat, vecs[i].abort_at, vecs[i].trig2_at);
        end

        // Reset mid-conversion must act before the next clock edge.
        trigger = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            trigger = 1'b0;
        end
        check("pre_reset cnv", 32'(cnv), 1);
        rst = 1'b1;
        #1;
        check("async_reset cnv", 32'(cnv), 0);
        check("async_reset busy", 32'(busy), 0);
        check("async_reset data", 32'(data), 0);
        check("async_reset done", 32'(done), 0);
        #2;
        rst = 1'b0;
        last_data = '0;
        @(posedge clk);
        #1;
        acquire("post_reset", 32'h2A5C3, 0, 0);

        // Random runs against the timing/overrun model.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] pat;
            int ab, t2;
            pat = $urandom & 32'h3FFFF;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 240)) : 0;
            t2  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 244)) : 0;
            acquire($sformatf("rand%0d", i), pat, ab, t2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
